hazard_forward_unit: RTL

- Sits directly upstream of the EX-stage operand muxes. Generates their 3-bit select codes: 000 = register file, 001 = EX/MEM result, 010 = MEM/WB result.
- Keeps its own shadow pipeline (EX, MEM, WB) of destination-register info to compute forwarding.
- Detects load-use hazards: stalls IF/ID and injects a bubble into EX.
- Keeps a saturating stall-cycle counter for performance stats.

---
 rtl/cpu_fwd_pkg.sv | 32 +++
 rtl/fwd_select_calc.sv | 25 ++
 rtl/hazard_forward_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_fwd_pkg.sv
// Shared types for the EX-stage forwarding / load-use hazard unit.
// The shadow slots hold only what forwarding needs: valid, rd, write-enable and load flag.
package cpu_fwd_pkg;

  localparam int FWD_REG_ADDR_W = 4;

  typedef enum logic [2:0] {
    FWD_REGFILE = 3'b000,
    FWD_EXMEM   = 3'b001,
    FWD_MEMWB   = 3'b010
  } fwd_sel_t;

  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rd;
    logic                      we;
    logic                      is_load;
  } ex_slot_t;

  // MEM and WB slots share a layout; the load flag is no longer interesting past EX
  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rd;
    logic                      we;
  } mw_slot_t;

  function automatic logic is_writer(input logic v, input logic we,
                                     input logic [FWD_REG_ADDR_W-1:0] rd);
    return v & we & (rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select_calc.sv
// Per-operand forwarding select: youngest producer (EX/MEM) beats MEM/WB; r0 never forwards.
module fwd_select_calc
  import cpu_fwd_pkg::*;
(
  input  logic [FWD_REG_ADDR_W-1:0] rs_i,
  input  logic                      used_i,
  input  ex_slot_t                  ex_i,
  input  mw_slot_t                  mem_i,
  output fwd_sel_t                  sel_o
);

  logic live, ex_hit, mem_hit;

  assign live = used_i & (rs_i != '0);
  // A load in EX has no data yet; the stall path turns that case into a MEM/WB forward
  assign ex_hit  = live & is_writer(ex_i.valid, ex_i.we, ex_i.rd) & ~ex_i.is_load & (rs_i == ex_i.rd);
  assign mem_hit = live & is_writer(mem_i.valid, mem_i.we, mem_i.rd) & (rs_i == mem_i.rd);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (ex_hit)       sel_o = FWD_EXMEM;
    else if (mem_hit) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow EX/MEM/WB pipeline of destination info, registered operand-mux selects,
// load-use stall generation and a saturating stall-cycle counter.
module hazard_forward_unit
  import cpu_fwd_pkg::*;
#(
  parameter int REG_ADDR_W = FWD_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_is_load_i,
  input  logic                  stats_clr_i,
  output logic                  stall_o,
  output logic [2:0]            fwd_sel_a_o,
  output logic [2:0]            fwd_sel_b_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int NUM_OPS = 2;

  ex_slot_t                          ex_q, ex_d;
  mw_slot_t                          mem_q, mem_d, wb_q, wb_d;
  logic [NUM_OPS-1:0][2:0]           sel_q, sel_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] rs_v;
  logic [NUM_OPS-1:0]                used_v;
  fwd_sel_t                          sel_c [NUM_OPS];
  logic                              ex_wr, hazard, bubble;

  assign rs_v   = {id_rs2_i, id_rs1_i};
  assign used_v = {id_rs2_used_i, id_rs1_used_i};

  assign ex_wr  = is_writer(ex_q.valid, ex_q.we, ex_q.rd);
  assign hazard = id_valid_i & ex_wr & ex_q.is_load &
                  ((id_rs1_used_i & (id_rs1_i == ex_q.rd)) |
                   (id_rs2_used_i & (id_rs2_i == ex_q.rd)));
  // Flush wins over a hazard: the dependent is being killed anyway
  assign stall_o = hazard & ~flush_i & ~freeze_i;
  assign bubble  = flush_i | stall_o | ~id_valid_i;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_select_calc u_calc (
      .rs_i   (rs_v[g]),
      .used_i (used_v[g]),
      .ex_i   (ex_q),
      .mem_i  (mem_q),
      .sel_o  (sel_c[g])
    );
  end

  always_comb begin
    mem_d = '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};
    wb_d  = mem_q;
    ex_d  = '0;
    sel_d = '0;
    if (!bubble) begin
      ex_d  = '{valid: 1'b1, rd: id_rd_i, we: id_we_i, is_load: id_is_load_i};
      sel_d = {sel_c[1], sel_c[0]};
    end
  end

  // Clear is honoured even while frozen; stall_o is already low during freeze
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr_i)                 cnt_d = '0;
    else if (stall_o && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      sel_q <= '0;
    end else if (!freeze_i) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      sel_q <= sel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // WB is tracked for completeness; distance-3 values come from the regfile bypass
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign fwd_sel_a_o = sel_q[0];
  assign fwd_sel_b_o = sel_q[1];
  assign stall_cnt_o = cnt_q;

endmodule
